// File: rtl/mips_mmio_timer.sv
// mips_mmio_timer: memory-mapped down-counting timer with a prescaler.
// It sits on the MIPS data port and decodes a 16-byte window at BASE_ADDR.
//
// Register map, selected by memaddr[3:2]:
//   0 CTRL   : bit0 EN, bit1 AUTO, bit2 IE, bits[8+PSC_W-1:8] PSC
//   1 LOAD   : reload value
//   2 COUNT  : current count, writable
//   3 STATUS : bit0 EXP, write-1-to-clear
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   memwrite     CPU store strobe
//   memaddr      CPU byte address
//   memwritedata CPU store data
//   hit          address falls in the window (combinational)
//   rdata        selected register when hit, else 0 (combinational)
//   irq          EXP & IE, taken from registered state
module mips_mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          PSC_W     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [PSC_W-1:0] PSC_ONE = 1;

    logic             en, auto_rl, ie, exp_q;
    logic [PSC_W-1:0] psc, pcnt;
    logic [31:0]      load_q, count_q, ctrl_word;
    logic [1:0]       sel;
    logic             wr, wr_ctrl, wr_load, wr_count, wr_status;
    logic             tick, expire;
    logic             unused_ok;

    assign unused_ok = ^memaddr[1:0];

    assign hit = (memaddr[31:4] == BASE_ADDR[31:4]);
    assign sel = memaddr[3:2];

    always_comb begin
        ctrl_word             = '0;
        ctrl_word[0]          = en;
        ctrl_word[1]          = auto_rl;
        ctrl_word[2]          = ie;
        ctrl_word[8 +: PSC_W] = psc;
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (sel)
                2'd0:    rdata = ctrl_word;
                2'd1:    rdata = load_q;
                2'd2:    rdata = count_q;
                default: rdata = {31'd0, exp_q};
            endcase
        end
    end

    assign wr        = memwrite & hit;
    assign wr_ctrl   = wr && (sel == 2'd0);
    assign wr_load   = wr && (sel == 2'd1);
    assign wr_count  = wr && (sel == 2'd2);
    assign wr_status = wr && (sel == 2'd3);

    assign tick   = en && (pcnt == psc);
    // A CPU write to COUNT on a tick edge swallows the tick, expiry included.
    assign expire = tick && (count_q == 32'd0) && !wr_count;

    assign irq = exp_q & ie;

    always_ff @(posedge clk) begin
        if (!reset) begin
            en      <= 1'b0;
            auto_rl <= 1'b0;
            ie      <= 1'b0;
            psc     <= '0;
            pcnt    <= '0;
            load_q  <= '0;
            count_q <= '0;
            exp_q   <= 1'b0;
        end else begin
            // Prescaler restarts on a tick, while disabled, and when EN is
            // being switched on so the first tick lands PSC+1 edges later.
            if ((wr_ctrl && !en && memwritedata[0]) || !en || tick)
                pcnt <= '0;
            else
                pcnt <= pcnt + PSC_ONE;

            // Written EN wins over a one-shot expiry on the same edge.
            if (wr_ctrl) begin
                en      <= memwritedata[0];
                auto_rl <= memwritedata[1];
                ie      <= memwritedata[2];
                psc     <= memwritedata[8 +: PSC_W];
            end else if (expire && !auto_rl) begin
                en <= 1'b0;
            end

            if (wr_load)
                load_q <= memwritedata;

            // Expiry replaces a decrement from 0, so COUNT never wraps.
            if (wr_count)
                count_q <= memwritedata;
            else if (tick) begin
                if (count_q != 32'd0)
                    count_q <= count_q - 32'd1;
                else if (auto_rl)
                    count_q <= load_q;
            end

            // Set has priority over write-1-to-clear.
            if (expire)
                exp_q <= 1'b1;
            else if (wr_status && memwritedata[0])
                exp_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mmio_timer.sv
module tb_mips_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_LOAD = BASE + 32'h4;
    localparam logic [31:0] A_CNT  = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] memaddr = '0;
    logic [31:0] memwritedata = '0;
    logic        hit;
    logic [31:0] rdata;
    logic        irq;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    mips_mmio_timer #(.BASE_ADDR(BASE), .PSC_W(8)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .memaddr(memaddr),
        .memwritedata(memwritedata), .hit(hit), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memaddr = a; memwritedata = d; memwrite = 1'b1;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
    endtask

    task automatic expect_reg(input string nm, input logic [31:0] a, input logic [31:0] v);
        exp_t e;
        e.name = nm; e.addr = a; e.val = v;
        sb.push_back(e);
    endtask

    // Drain the scoreboard: each entry is a register read taken now.
    task automatic drain();
        exp_t e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            memwrite = 1'b0;
            memaddr  = e.addr;
            #1;
            got = rdata;
            n_chk++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_reset();
        memaddr = A_CNT; memwritedata = 32'h1234; memwrite = 1'b1;
        reset = 1'b0;
        step(2);
        reset = 1'b1; memwrite = 1'b0;
        expect_reg("rst_ctrl", A_CTRL, 32'h0);
        expect_reg("rst_load", A_LOAD, 32'h0);
        expect_reg("rst_count", A_CNT, 32'h0);
        expect_reg("rst_status", A_STAT, 32'h0);
        drain();
        n_chk++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b expected 0", irq); end
    endtask

    task automatic test_auto_reload();
        wr(A_LOAD, 32'd3);
        wr(A_CNT, 32'd3);
        wr(A_CTRL, 32'h7);                 // edge T
        for (int k = 1; k <= 3; k++) begin
            step(1);
            expect_reg("auto_count", A_CNT, 32'(3 - k));
            drain();
        end
        step(1);                           // T+4
        expect_reg("auto_exp", A_STAT, 32'h1);
        expect_reg("auto_reload", A_CNT, 32'd3);
        drain();
        n_chk++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL auto_irq: got %b expected 1", irq); end
        step(3);                           // T+7
        expect_reg("auto_pre2", A_CNT, 32'd0);
        drain();
        step(1);                           // T+8
        expect_reg("auto_2nd", A_CNT, 32'd3);
        drain();
        wr(A_STAT, 32'h1);
        n_chk++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL auto_irq_clr: got %b expected 0", irq); end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_one_shot();
        wr(A_STAT, 32'h1);
        wr(A_CNT, 32'd1);
        wr(A_CTRL, 32'h201);               // edge T
        step(2);
        expect_reg("os_hold", A_CNT, 32'd1);
        drain();
        step(1);                           // T+3
        expect_reg("os_dec", A_CNT, 32'd0);
        expect_reg("os_noexp", A_STAT, 32'd0);
        drain();
        step(3);                           // T+6
        expect_reg("os_exp", A_STAT, 32'h1);
        expect_reg("os_ctrl", A_CTRL, 32'h200);
        drain();
        step(20);
        expect_reg("os_stay0", A_CNT, 32'd0);
        drain();
    endtask

    task automatic test_collisions();
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h1);
        wr(A_LOAD, 32'h10);
        wr(A_CNT, 32'd5);
        wr(A_CTRL, 32'h1);                 // PSC=0: every edge ticks from here
        wr(A_CNT, 32'h55);                 // tick edge
        expect_reg("col_cnt_wr", A_CNT, 32'h55);
        drain();
        step(1);
        expect_reg("col_cnt_dec", A_CNT, 32'h54);
        drain();
        wr(A_CNT, 32'h0);
        wr(A_STAT, 32'h1);                 // expiry edge
        expect_reg("col_stat_set", A_STAT, 32'h1);
        expect_reg("col_oneshot_en", A_CTRL, 32'h0);
        drain();
        wr(A_STAT, 32'h1);
        wr(A_CTRL, 32'h1);
        wr(A_CNT, 32'h0);
        wr(A_CTRL, 32'h5);                 // expiry edge, written EN wins
        expect_reg("col_ctrl_wins", A_CTRL, 32'h5);
        expect_reg("col_ctrl_exp", A_STAT, 32'h1);
        drain();
        n_chk++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL col_irq: got %b expected 1", irq); end
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h1);
    endtask

    task automatic test_decode();
        logic [31:0] bad [2];
        wr(A_CNT, 32'h77);
        bad[0] = BASE + 32'h10;
        bad[1] = BASE - 32'h4;
        for (int i = 0; i < 2; i++) begin
            memaddr = bad[i]; memwritedata = 32'hFFFF_FFFF; memwrite = 1'b1;
            #1;
            n_chk++;
            if (hit !== 1'b0 || rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL dec_out%0d: got hit=%b rdata=%h expected hit=0 rdata=0", i, hit, rdata);
            end
            @(posedge clk);
            #1;
            memwrite = 1'b0;
        end
        expect_reg("dec_ctrl", A_CTRL, 32'h0);
        expect_reg("dec_load", A_LOAD, 32'h10);
        expect_reg("dec_count", A_CNT, 32'h77);
        expect_reg("dec_stat", A_STAT, 32'h0);
        expect_reg("dec_low_bits", BASE + 32'h6, 32'h10);
        drain();
    endtask

    task automatic test_mid_reset();
        wr(A_CNT, 32'd100);
        wr(A_CTRL, 32'h5);
        step(1);
        expect_reg("mr_running", A_CNT, 32'd99);
        drain();
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        expect_reg("mr_count", A_CNT, 32'd0);
        expect_reg("mr_ctrl", A_CTRL, 32'd0);
        drain();
        n_chk++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL mr_irq: got %b expected 0", irq); end
        step(3);
        expect_reg("mr_no_tick", A_CNT, 32'd0);
        expect_reg("mr_no_exp", A_STAT, 32'd0);
        drain();
    endtask

    initial begin
        step(1);
        test_reset();
        test_auto_reload();
        test_one_shot();
        test_collisions();
        test_decode();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mmio_timer.md
Name: mips_mmio_timer

Overview:
- Memory-mapped down-counting timer on the MIPS CPU data port, directly downstream of the core's memwrite/memaddr/memwritedata outputs.
- Decodes a 16-byte window at BASE_ADDR and exposes four 32-bit registers. Reads return combinationally so the core can use them in the same cycle.
- Drives a level interrupt flag that the system polls or routes.

Parameters:
- BASE_ADDR, 32'h0000_7F00, window base. Bits [3:0] are ignored for decode and must be 0.
- PSC_W, 8, prescaler width. CTRL[8+PSC_W-1:8] holds the prescale value PSC.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset. 0 at a rising edge clears all state.
- memwrite  in  1  CPU store strobe.
- memaddr  in  32  CPU byte address.
- memwritedata  in  32  CPU store data.
- hit  out  1  memaddr[31:4]==BASE_ADDR[31:4]. Combinational; the system uses it to mux read data.
- rdata  out  32  selected register when hit, else 32'h0. Combinational.
- irq  out  1  STATUS.EXP & CTRL.IE, from registered state only.

Behaviour:
- Register map, by memaddr[3:2]; memaddr[1:0] ignored:
  - 0 CTRL: bit0 EN, bit1 AUTO, bit2 IE, bits[8+PSC_W-1:8] PSC. Other bits read 0.
  - 1 LOAD: reload value.
  - 2 COUNT: current count. Writable.
  - 3 STATUS: bit0 EXP. Write-1-to-clear; other bits read 0.
- Write occurs at the rising edge when memwrite & hit. No side effects on reads.
- Reset (reset==0 at edge): CTRL, LOAD, COUNT, STATUS and prescaler counter all 0, so irq=0.
- Reset takes priority over any concurrent write or tick.
- Prescaler (pcnt, PSC_W bits):
  - When EN=1: if pcnt==PSC, tick=1 and pcnt<=0; else pcnt<=pcnt+1.
  - When EN=0: pcnt<=0 and no tick.
  - PSC=0 gives a tick every enabled cycle.
- Tick action:
  - COUNT!=0: COUNT<=COUNT-1.
  - COUNT==0: EXP<=1 (expiry). Then if AUTO, COUNT<=LOAD and EN stays 1; if not AUTO, COUNT stays 0 and EN<=0 (one-shot).
  - Period is (LOAD+1)*(PSC+1) cycles.
- Writing CTRL while EN transitions 0->1 forces pcnt<=0, so the first tick occurs PSC+1 edges after the write edge.
- Writing LOAD never alters COUNT.
- Simultaneous events:
  - CPU write to COUNT with a tick at the same edge: the write wins, and no decrement or expiry occurs.
  - CPU write to CTRL with a one-shot expiry at the same edge: the written EN wins, and EXP still sets.
  - STATUS write-1 with an expiry at the same edge: EXP ends at 1 (set wins).
  - Writing 0 to STATUS bit0 has no effect.
- Wrap: COUNT never underflows. Expiry replaces a decrement from 0.
- Outside the window: hit=0, rdata=0, and stores are ignored.
- Latency: register writes are visible on rdata the cycle after the write edge; irq follows EXP/IE with one edge of latency.

Test Plan:
1. Reset: assert reset=0 for 2 edges with a CPU write pending, then read all 4 registers -> all 0, irq=0. Pending write ignored.
2. Auto-reload, PSC=0: write LOAD=3, COUNT=3, then CTRL=0x7 at edge T. Required:
   - COUNT reads 2,1,0 after T+1..T+3.
   - At T+4, EXP=1, irq=1, COUNT=3.
   - Next expiry at T+8.
   - Writing STATUS=1 clears irq on the next cycle.
3. One-shot, PSC=2: write COUNT=1, then CTRL=0x201 at edge T. Required:
   - COUNT=0 after T+3.
   - EXP=1 after T+6, CTRL reads 0x200 (EN cleared).
   - COUNT holds 0 for 20 further cycles.
4. Collisions:
   - Write COUNT=0x55 on an edge that is also a tick -> COUNT=0x55 next cycle, no decrement.
   - Write STATUS=1 on an expiry edge -> EXP stays 1.
5. Decode: memaddr=BASE_ADDR+0x10 and BASE_ADDR-4 with memwrite=1 -> hit=0, rdata=0, registers unchanged. memaddr=BASE_ADDR+0x6 read -> returns LOAD.
6. Mid-run reset: with timer running (PSC=0, COUNT=100), assert reset=0 for 1 edge -> next cycle COUNT=0, EN=0, irq=0, with no tick afterwards.
